// File: rtl/rb_arb_pkg.sv
// Shared sizing constants and slot record for the readback arbiter.
package rb_arb_pkg;

  localparam int unsigned RB_N_CH    = 6;
  localparam int unsigned RB_DATA_W  = 28;
  localparam int unsigned RB_ADDR_W  = 4;
  localparam int unsigned RB_PTR_RST = RB_N_CH - 1;

  typedef struct packed {
    logic                 full;
    logic                 urgent;
    logic [RB_DATA_W-1:0] payload;
  } slot_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set mask bit searching upward from last+1, wrapping.
module rr_pick
  import rb_arb_pkg::*;
#(
  parameter int unsigned N  = RB_N_CH,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last) + k) % N);
      if (!any && mask[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readback_arbiter.sv
// Serialises per-channel readback words into one output port, round-robin with one-entry slots.
// Optional RB_ARB_URGENT_EN: urgent-tagged slots win over normal ones and drive out_urgent.
module readback_arbiter
  import rb_arb_pkg::*;
#(
  parameter int unsigned N_CH   = RB_N_CH,
  parameter int unsigned DATA_W = RB_DATA_W,
  parameter int unsigned ADDR_W = RB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*DATA_W-1:0] bus_in,
  output logic [N_CH-1:0]        busy,
  output logic                   out_stb,
  output logic [DATA_W-1:0]      out_data,
  output logic [ADDR_W-1:0]      out_addr,
  input  logic                   out_rdy,
  output logic [N_CH-1:0]        ovf,
`ifdef RB_ARB_URGENT_EN
  input  logic [N_CH-1:0]        urgent,
  output logic                   out_urgent,
`endif
  input  logic                   ovf_clr
);

  localparam int unsigned IW = $clog2(N_CH);

  slot_t              slot_q [N_CH];
  slot_t              slot_d [N_CH];
  logic [N_CH-1:0]    full_vec;
  logic [N_CH-1:0]    ovf_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win;
  logic [N_CH-1:0]    win_oh;
  logic               win_any;
  logic               out_stb_d;
  logic [DATA_W-1:0]  out_data_d;
  logic [ADDR_W-1:0]  out_addr_d;

  always_comb begin
    full_vec = '0;
    for (int unsigned i = 0; i < N_CH; i++) full_vec[i] = slot_q[i].full;
  end

  assign busy = full_vec;

`ifdef RB_ARB_URGENT_EN
  logic [N_CH-1:0] urg_vec, u_grant, n_grant;
  logic [IW-1:0]   u_idx, n_idx;
  logic            u_any, n_any;
  logic            out_urgent_d;

  always_comb begin
    urg_vec = '0;
    for (int unsigned i = 0; i < N_CH; i++) urg_vec[i] = slot_q[i].urgent;
  end

  // Urgent slots are searched first; both searches share the same pointer.
  rr_pick #(.N(N_CH), .IW(IW)) u_pick_urg (
    .mask  (full_vec & urg_vec),
    .last  (ptr_q),
    .grant (u_grant),
    .idx   (u_idx),
    .any   (u_any)
  );

  rr_pick #(.N(N_CH), .IW(IW)) u_pick_norm (
    .mask  (full_vec & ~urg_vec),
    .last  (ptr_q),
    .grant (n_grant),
    .idx   (n_idx),
    .any   (n_any)
  );

  assign win     = u_any ? u_idx : n_idx;
  assign win_oh  = u_any ? u_grant : n_grant;
  assign win_any = u_any | n_any;
`else
  rr_pick #(.N(N_CH), .IW(IW)) u_pick (
    .mask  (full_vec),
    .last  (ptr_q),
    .grant (win_oh),
    .idx   (win),
    .any   (win_any)
  );
`endif

  // Capture uses the pre-edge full flags, so a same-cycle drain never frees a slot for capture.
  always_comb begin
    slot_d     = slot_q;
    ovf_d      = ovf_clr ? '0 : ovf;
    ptr_d      = ptr_q;
    out_stb_d  = 1'b0;
    out_data_d = out_data;
    out_addr_d = out_addr;
`ifdef RB_ARB_URGENT_EN
    out_urgent_d = out_urgent;
`endif
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (req[i]) begin
        if (slot_q[i].full) begin
          ovf_d[i] = 1'b1;
        end else begin
          slot_d[i].full    = 1'b1;
          slot_d[i].payload = RB_DATA_W'(bus_in[i*DATA_W +: DATA_W]);
`ifdef RB_ARB_URGENT_EN
          slot_d[i].urgent  = urgent[i];
`else
          slot_d[i].urgent  = 1'b0;
`endif
        end
      end
    end
    if (out_rdy && win_any) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (win_oh[i]) slot_d[i].full = 1'b0;
      end
      out_stb_d  = 1'b1;
      out_data_d = DATA_W'(slot_q[win].payload);
      out_addr_d = ADDR_W'(win);
      ptr_d      = win;
`ifdef RB_ARB_URGENT_EN
      out_urgent_d = slot_q[win].urgent;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) slot_q[i] <= '0;
      ovf      <= '0;
      ptr_q    <= IW'(N_CH - 1);
      out_stb  <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
`ifdef RB_ARB_URGENT_EN
      out_urgent <= 1'b0;
`endif
    end else begin
      slot_q   <= slot_d;
      ovf      <= ovf_d;
      ptr_q    <= ptr_d;
      out_stb  <= out_stb_d;
      out_data <= out_data_d;
      out_addr <= out_addr_d;
`ifdef RB_ARB_URGENT_EN
      out_urgent <= out_urgent_d;
`endif
    end
  end

endmodule

// File: tb/tb_readback_arbiter.sv
// Self-checking bench for readback_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_readback_arbiter;

  localparam int N  = 6;
  localparam int DW = 28;
  localparam int AW = 4;
  localparam int VW = 1 + AW + DW + N + N + 1;
`ifdef RB_ARB_URGENT_EN
  localparam bit URG_EN = 1'b1;
`else
  localparam bit URG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] bus_in;
  logic [N-1:0]    busy;
  logic            out_stb;
  logic [DW-1:0]   out_data;
  logic [AW-1:0]   out_addr;
  logic            out_rdy;
  logic [N-1:0]    ovf;
  logic            ovf_clr;
  logic [N-1:0]    urgent;
  logic            out_urgent_w;

  readback_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .bus_in     (bus_in),
    .busy       (busy),
    .out_stb    (out_stb),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_rdy    (out_rdy),
    .ovf        (ovf),
`ifdef RB_ARB_URGENT_EN
    .urgent     (urgent),
    .out_urgent (out_urgent_w),
`endif
    .ovf_clr    (ovf_clr)
  );

`ifndef RB_ARB_URGENT_EN
  assign out_urgent_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model: one pending word per channel, last-served channel, sticky overflow.
  logic [N-1:0]  m_full, m_ovf, m_urgq;
  logic [DW-1:0] m_pay [N];
  int            m_ptr;
  logic          m_stb, m_ourg;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;

  int n_cmp = 0;
  int n_fail = 0;

  wire [VW-1:0] dut_vec = {out_stb, out_addr, out_data, busy, ovf, out_urgent_w};

  function automatic logic [VW-1:0] model_vec();
    return {m_stb, m_addr, m_data, m_full, m_ovf, m_ourg};
  endfunction

  task automatic model_reset();
    m_full = '0; m_ovf = '0; m_urgq = '0; m_ptr = N - 1;
    m_stb = 1'b0; m_ourg = 1'b0; m_data = '0; m_addr = '0;
    for (int i = 0; i < N; i++) m_pay[i] = '0;
  endtask

  task automatic model_clk();
    int w;
    logic [N-1:0] old;
    w = -1;
    old = m_full;
    if (out_rdy) begin
      if (URG_EN)
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (w < 0 && old[c] && m_urgq[c]) w = c;
        end
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && old[c]) w = c;
      end
    end
    m_stb = (w >= 0);
    if (ovf_clr) m_ovf = '0;
    if (w >= 0) begin
      m_data = m_pay[w]; m_addr = AW'(w); m_ourg = m_urgq[w];
      m_ptr = w; m_full[w] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (old[i]) m_ovf[i] = 1'b1;
        else begin
          m_full[i] = 1'b1;
          m_pay[i]  = bus_in[i*DW +: DW];
          m_urgq[i] = URG_EN & urgent[i];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_clk();
    @(negedge clk);
  endtask

  task automatic set_word(input int ch, input logic [DW-1:0] v);
    bus_in[ch*DW +: DW] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; bus_in = '0; out_rdy = 1'b0; ovf_clr = 1'b0; urgent = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL reset_in: got %h want 0", dut_vec);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reset_out: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_fairness();
    logic [DW-1:0] pay [N];
    int order [N];
    out_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin pay[i] = DW'($urandom); set_word(i, pay[i]); end
    req = '1; step(); req = '0;
    for (int i = 0; i < N; i++) begin
      step();
      n_cmp++;
      if (!(out_stb === 1'b1 && out_addr === AW'(i) && out_data === pay[i]) || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL fair1[%0d]: stb=%b addr=%0d data=%h want addr=%0d data=%h", i, out_stb, out_addr, out_data, i, pay[i]);
      end
    end
    req = 6'b001000; step(); req = '0; step();
    n_cmp++;
    if (out_stb !== 1'b1 || out_addr !== AW'(3)) begin
      n_fail++; $display("FAIL fair_ptr3: stb=%b addr=%0d want 1/3", out_stb, out_addr);
    end
    order = '{4, 5, 0, 1, 2, 3};
    for (int i = 0; i < N; i++) begin pay[i] = DW'($urandom); set_word(i, pay[i]); end
    req = '1; step(); req = '0;
    for (int i = 0; i < N; i++) begin
      step();
      n_cmp++;
      if (!(out_stb === 1'b1 && out_addr === AW'(order[i]) && out_data === pay[order[i]])) begin
        n_fail++; $display("FAIL fair2[%0d]: addr=%0d data=%h want addr=%0d data=%h", i, out_addr, out_data, order[i], pay[order[i]]);
      end
    end
  endtask

  task automatic test_single();
    out_rdy = 1'b1;
    set_word(2, 28'h0ABCDEF);
    req = 6'b000100; step(); req = '0;
    n_cmp++;
    if (busy !== 6'b000100 || out_stb !== 1'b0) begin
      n_fail++; $display("FAIL single_cap: busy=%b stb=%b want 000100/0", busy, out_stb);
    end
    step();
    n_cmp++;
    if (out_stb !== 1'b1 || out_addr !== 4'd2 || out_data !== 28'h0ABCDEF || busy !== '0) begin
      n_fail++; $display("FAIL single_out: stb=%b addr=%0d data=%h busy=%b want 1/2/0abcdef/0", out_stb, out_addr, out_data, busy);
    end
    step();
    n_cmp++;
    if (dut_vec !== model_vec() || out_stb !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_backpressure();
    int seen;
    out_rdy = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, DW'($urandom));
    req = 6'b100101; step(); req = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (out_stb !== 1'b0 || busy !== 6'b100101 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL bp_stall[%0d]: stb=%b busy=%b want 0/100101", c, out_stb, busy);
      end
    end
    out_rdy = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (out_stb !== 1'b1 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL bp_drain[%0d]: got %h want %h", c, dut_vec, model_vec());
      end else seen++;
    end
    step();
    n_cmp++;
    if (busy !== '0 || out_stb !== 1'b0 || seen != 3) begin
      n_fail++; $display("FAIL bp_done: busy=%b stb=%b drained=%0d want 0/0/3", busy, out_stb, seen);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] a, b;
    a = DW'($urandom); b = ~a;
    out_rdy = 1'b0;
    set_word(1, a); req = 6'b000010; step();
    set_word(1, b); step(); req = '0;
    n_cmp++;
    if (ovf !== 6'b000010 || busy !== 6'b000010) begin
      n_fail++; $display("FAIL ovf_set: ovf=%b busy=%b want 000010/000010", ovf, busy);
    end
    out_rdy = 1'b1; step();
    n_cmp++;
    if (out_stb !== 1'b1 || out_addr !== 4'd1 || out_data !== a) begin
      n_fail++; $display("FAIL ovf_keep: stb=%b addr=%0d data=%h want 1/1/%h", out_stb, out_addr, out_data, a);
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== '0) begin
      n_fail++; $display("FAIL ovf_clr: ovf=%b want 0", ovf);
    end
    out_rdy = 1'b0;
    set_word(1, b); req = 6'b000010; step();
    ovf_clr = 1'b1; step(); req = '0; ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== 6'b000010 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL ovf_setwins: ovf=%b want 000010", ovf);
    end
    out_rdy = 1'b1; step();
    n_cmp++;
    if (out_data !== b || out_stb !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drain: data=%h stb=%b want %h/1", out_data, out_stb, b);
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, DW'($urandom));
    req = 6'b011011; step(); req = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL rstmid_vals: got %h want 0", dut_vec);
    end
    @(negedge clk); rst_n = 1'b1; out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (out_stb !== 1'b0 || busy !== '0 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL rstmid_quiet[%0d]: stb=%b busy=%b want 0/0", c, out_stb, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req     = N'($urandom) & N'($urandom);
      urgent  = N'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) set_word(i, DW'($urandom));
      step();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", c, dut_vec, model_vec());
      end
    end
    req = '0; urgent = '0; ovf_clr = 1'b0; out_rdy = 1'b1;
    repeat (N + 1) step();
    n_cmp++;
    if (busy !== '0 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL random_flush: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_urgent();
    if (URG_EN) begin
      out_rdy = 1'b0;
      set_word(0, DW'($urandom)); set_word(4, DW'($urandom));
      urgent = 6'b010000; req = 6'b010001; step(); req = '0; urgent = '0;
      out_rdy = 1'b1; step();
      n_cmp++;
      if (out_addr !== 4'd4 || out_urgent_w !== 1'b1 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL urg_first: addr=%0d urg=%b want 4/1", out_addr, out_urgent_w);
      end
      step();
      n_cmp++;
      if (out_addr !== 4'd0 || out_urgent_w !== 1'b0 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL urg_second: addr=%0d urg=%b want 0/0", out_addr, out_urgent_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_urgent();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
